// File: rtl/vga_pkg.sv
// Shared VGA stream definitions: field positions inside strVGA and the
// default 640x480@60 timing. Used by the timing source and its consumers.
package vga_pkg;

    // strVGA field layout: {active, vsync, hsync, y[9:0], x[9:0]}
    localparam int STR_X_LSB = 0;
    localparam int STR_Y_LSB = 10;
    localparam int STR_HS    = 20;
    localparam int STR_VS    = 21;
    localparam int STR_ACT   = 22;
    localparam int STR_W     = 23;
    localparam int RGB_W     = 26;

    localparam int COORD_W   = 10;
    localparam int MAX_TOTAL = 1 << COORD_W;

    // 640x480@60 defaults
    localparam int H_ACTIVE_DEF = 640;
    localparam int H_FP_DEF     = 16;
    localparam int H_SYNC_DEF   = 96;
    localparam int H_BP_DEF     = 48;
    localparam int V_ACTIVE_DEF = 480;
    localparam int V_FP_DEF     = 10;
    localparam int V_SYNC_DEF   = 2;
    localparam int V_BP_DEF     = 33;

    typedef logic [STR_W-1:0] vga_stream_t;

    // Full period of one axis (line length or frame height)
    function automatic int axis_total(int act, int fp, int sync, int bp);
        return act + fp + sync + bp;
    endfunction

endpackage

// File: rtl/vga_stream_gen_if.sv
// Stream bundle between the timing source (master) and the Pong pipeline (slave).
interface vga_stream_gen_if;
    import vga_pkg::*;

    logic        enable;
    vga_stream_t strVGA;
    logic        endframe;
    logic [7:0]  frame_cnt;

    modport master (input enable, output strVGA, output endframe, output frame_cnt);
    modport slave  (output enable, input strVGA, input endframe, input frame_cnt);
endinterface

// File: rtl/vga_timing_axis.sv
// One timing axis: position counter that advances on i_tick and wraps at
// the end of the period, with active-region and sync-pulse decode.
module vga_timing_axis
    import vga_pkg::*;
#(
    parameter int ACTIVE = 640,
    parameter int FP     = 16,
    parameter int SYNC   = 96,
    parameter int BP     = 48,
    parameter bit POL    = 1'b0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_tick,
    output logic [COORD_W-1:0] o_cnt,
    output logic               o_wrap,
    output logic               o_active,
    output logic               o_sync
);
    localparam int TOTAL = axis_total(ACTIVE, FP, SYNC, BP);
    localparam logic [COORD_W-1:0] LAST = COORD_W'(TOTAL - 1);

    // The coordinate fields are COORD_W bits wide, so the period must fit.
    generate
        if (TOTAL > MAX_TOTAL) begin : g_bad_total
            $error("vga_timing_axis: period %0d exceeds %0d", TOTAL, MAX_TOTAL);
        end
    endgenerate

    logic [COORD_W-1:0] r_cnt;
    logic               w_in_sync;

    // Position counter: holds when not ticked, wraps after the last position
    always_ff @(posedge clk or posedge rst) begin
        if (rst)         r_cnt <= '0;
        else if (i_tick) r_cnt <= o_wrap ? '0 : r_cnt + 1'b1;
    end

    assign o_cnt     = r_cnt;
    assign o_wrap    = i_tick && (r_cnt == LAST);
    assign o_active  = int'(r_cnt) < ACTIVE;
    assign w_in_sync = (int'(r_cnt) >= ACTIVE + FP) && (int'(r_cnt) < ACTIVE + FP + SYNC);
    assign o_sync    = w_in_sync ? POL : ~POL;

endmodule

// File: rtl/vga_stream_gen.sv
// Pixel-timing source for the Pong pipeline: registered VGA stream,
// end-of-frame pulse on the last visible pixel, and a frame counter.
module vga_stream_gen
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int H_FP     = H_FP_DEF,
    parameter int H_SYNC   = H_SYNC_DEF,
    parameter int H_BP     = H_BP_DEF,
    parameter int V_ACTIVE = V_ACTIVE_DEF,
    parameter int V_FP     = V_FP_DEF,
    parameter int V_SYNC   = V_SYNC_DEF,
    parameter int V_BP     = V_BP_DEF,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0
) (
    input  logic px_clk,
    input  logic reset,
    vga_stream_gen_if.master bus
);
    localparam vga_stream_t STR_IDLE = {1'b0, ~VS_POL, ~HS_POL, 20'd0};

    logic [COORD_W-1:0] w_hc, w_vc;
    logic               w_h_wrap, w_h_act, w_hs;
    logic               w_unused_v_wrap, w_v_act, w_vs;
    logic               w_v_tick, w_last_px;

    vga_stream_t r_str;
    logic        r_endframe;
    logic [7:0]  r_frame_cnt;

    // Horizontal axis advances every enabled pixel clock
    vga_timing_axis #(
        .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP), .POL(HS_POL)
    ) u_h (
        .clk(px_clk), .rst(reset), .i_tick(bus.enable),
        .o_cnt(w_hc), .o_wrap(w_h_wrap), .o_active(w_h_act), .o_sync(w_hs)
    );

    // Vertical axis advances when the line wraps (wrap already implies enable)
    assign w_v_tick = w_h_wrap & bus.enable;

    vga_timing_axis #(
        .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP), .POL(VS_POL)
    ) u_v (
        .clk(px_clk), .rst(reset), .i_tick(w_v_tick),
        .o_cnt(w_vc), .o_wrap(w_unused_v_wrap), .o_active(w_v_act), .o_sync(w_vs)
    );

    assign w_last_px = (int'(w_hc) == H_ACTIVE - 1) && (int'(w_vc) == V_ACTIVE - 1);

    // Output registers: stream describes the previous cycle's position;
    // endframe is cleared whenever frozen so it never repeats.
    always_ff @(posedge px_clk or posedge reset) begin
        if (reset) begin
            r_str       <= STR_IDLE;
            r_endframe  <= 1'b0;
            r_frame_cnt <= 8'd0;
        end else begin
            r_endframe <= 1'b0;
            if (bus.enable) begin
                r_str      <= {w_h_act & w_v_act, w_vs, w_hs, w_vc, w_hc};
                r_endframe <= w_last_px;
                if (w_last_px) r_frame_cnt <= r_frame_cnt + 8'd1;
            end
        end
    end

    assign bus.strVGA    = r_str;
    assign bus.endframe  = r_endframe;
    assign bus.frame_cnt = r_frame_cnt;

endmodule

// File: tb/tb_vga_stream_gen.sv
// Directed bench: default-timing instance for line/freeze/reset checks,
// small-timing instances (active-low and active-high hsync) for frame checks.
module tb_vga_stream_gen;
    import vga_pkg::*;

    logic px_clk = 1'b0;
    logic reset;
    always #5 px_clk = ~px_clk;

    vga_stream_gen_if if_def ();
    vga_stream_gen_if if_small ();
    vga_stream_gen_if if_pol ();
    assign if_pol.enable = if_small.enable;

    vga_stream_gen u_def (.px_clk(px_clk), .reset(reset), .bus(if_def));

    vga_stream_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1)
    ) u_small (.px_clk(px_clk), .reset(reset), .bus(if_small));

    vga_stream_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1), .HS_POL(1'b1)
    ) u_pol (.px_clk(px_clk), .reset(reset), .bus(if_pol));

    int n_chk  = 0;
    int n_pass = 0;
    int ex, ey, since_pulse;

    task automatic step(input int n);
        repeat (n) @(posedge px_clk);
        #1;
    endtask

    // Expected stream of the small 14x7 timing (hsync 10..11, vsync line 5)
    function automatic vga_stream_t sm_exp(input int x, input int y, input bit hpol);
        logic       act, hin, vin;
        logic [9:0] xv, yv;
        act = (x < 8) && (y < 4);
        hin = (x >= 10) && (x < 12);
        vin = (y == 5);
        xv  = 10'(x);
        yv  = 10'(y);
        return {act, vin ? 1'b0 : 1'b1, hin ? hpol : ~hpol, yv, xv};
    endfunction

    task automatic test_reset();
        reset = 1'b1;
        if_def.enable = 1'b1;
        if_small.enable = 1'b1;
        step(3);
        n_chk++; if (if_def.strVGA !== 23'h300000) $display("FAIL rst_str_def: got %h exp 300000", if_def.strVGA); else n_pass++;
        n_chk++; if (if_pol.strVGA !== 23'h200000) $display("FAIL rst_str_pol: got %h exp 200000", if_pol.strVGA); else n_pass++;
        n_chk++; if (if_def.endframe !== 1'b0 || if_def.frame_cnt !== 8'd0)
            $display("FAIL rst_ef_fc: got ef=%b fc=%0d exp 0/0", if_def.endframe, if_def.frame_cnt); else n_pass++;
        reset = 1'b0;
        step(1);
        n_chk++; if (if_def.strVGA !== 23'h700000) $display("FAIL first_px_def: got %h exp 700000", if_def.strVGA); else n_pass++;
        n_chk++; if (if_small.strVGA !== 23'h700000) $display("FAIL first_px_small: got %h exp 700000", if_small.strVGA); else n_pass++;
    endtask

    task automatic test_line();
        int n_low = 0, first = -1, last = -1, x_err = 0, act_err = 0, ef_err = 0;
        for (int i = 1; i < 800; i++) begin
            step(1);
            if (int'(if_def.strVGA[9:0]) != i || if_def.strVGA[19:10] != 10'd0) x_err++;
            if (if_def.strVGA[STR_ACT] !== (i < 640)) act_err++;
            if (if_def.endframe !== 1'b0) ef_err++;
            if (if_def.strVGA[STR_HS] === 1'b0) begin
                n_low++;
                if (first < 0) first = i;
                last = i;
            end
        end
        n_chk++; if (x_err != 0) $display("FAIL line_x: got %0d errors exp 0", x_err); else n_pass++;
        n_chk++; if (act_err != 0) $display("FAIL line_active: got %0d errors exp 0", act_err); else n_pass++;
        n_chk++; if (ef_err != 0) $display("FAIL line_endframe: got %0d errors exp 0", ef_err); else n_pass++;
        n_chk++; if (n_low != 96) $display("FAIL hsync_len: got %0d exp 96", n_low); else n_pass++;
        n_chk++; if (first != 656 || last != 751) $display("FAIL hsync_pos: got %0d..%0d exp 656..751", first, last); else n_pass++;
        step(1);
        n_chk++; if (if_def.strVGA[19:0] !== {10'd1, 10'd0})
            $display("FAIL line_wrap: got y=%0d x=%0d exp y=1 x=0", if_def.strVGA[19:10], if_def.strVGA[9:0]); else n_pass++;
    endtask

    task automatic test_freeze();
        int frz_err = 0;
        step(300);
        n_chk++; if (if_def.strVGA[9:0] !== 10'd300) $display("FAIL pre_freeze_x: got %0d exp 300", if_def.strVGA[9:0]); else n_pass++;
        if_def.enable = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step(1);
            if (if_def.strVGA[9:0] !== 10'd300 || if_def.strVGA[19:10] !== 10'd1 || if_def.endframe !== 1'b0) frz_err++;
        end
        n_chk++; if (frz_err != 0) $display("FAIL freeze_hold: got %0d errors exp 0", frz_err); else n_pass++;
        if_def.enable = 1'b1;
        step(1);
        n_chk++; if (if_def.strVGA[9:0] !== 10'd301) $display("FAIL freeze_resume: got %0d exp 301", if_def.strVGA[9:0]); else n_pass++;
        step(199);
        n_chk++; if (if_def.strVGA[9:0] !== 10'd500) $display("FAIL pre_reset_x: got %0d exp 500", if_def.strVGA[9:0]); else n_pass++;
    endtask

    task automatic test_reset_mid();
        n_chk++; if (if_small.frame_cnt === 8'd0) $display("FAIL pre_reset_fc: got 0 exp nonzero"); else n_pass++;
        #2;
        reset = 1'b1;
        #1;
        n_chk++; if (if_def.strVGA !== 23'h300000) $display("FAIL async_rst_def: got %h exp 300000", if_def.strVGA); else n_pass++;
        n_chk++; if (if_small.strVGA !== 23'h300000 || if_small.frame_cnt !== 8'd0)
            $display("FAIL async_rst_small: got %h fc=%0d exp 300000 fc=0", if_small.strVGA, if_small.frame_cnt); else n_pass++;
        step(2);
        n_chk++; if (if_def.strVGA !== 23'h300000 || if_def.endframe !== 1'b0)
            $display("FAIL rst_hold: got %h ef=%b exp 300000 ef=0", if_def.strVGA, if_def.endframe); else n_pass++;
        reset = 1'b0;
        step(1);
        n_chk++; if (if_def.strVGA !== 23'h700000) $display("FAIL restart_def: got %h exp 700000", if_def.strVGA); else n_pass++;
        ex = 0;
        ey = 0;
    endtask

    task automatic test_frame();
        int str_err = 0, pol_err = 0, ef_err = 0, fc_err = 0, pulses = 0, last_pulse = -1, period = 0;
        int exp_fc = 0;
        bit efx;
        for (int c = 1; c <= 196; c++) begin
            ex++;
            if (ex == 14) begin ex = 0; ey++; if (ey == 7) ey = 0; end
            step(1);
            efx = (ex == 7) && (ey == 3);
            if (efx) exp_fc++;
            if (if_small.strVGA !== sm_exp(ex, ey, 1'b0)) str_err++;
            if (if_pol.strVGA !== sm_exp(ex, ey, 1'b1)) pol_err++;
            if (if_small.endframe !== efx || if_pol.endframe !== efx) ef_err++;
            if (int'(if_small.frame_cnt) != exp_fc) fc_err++;
            if (if_small.endframe === 1'b1) begin
                if (pulses == 1) period = c - last_pulse;
                pulses++;
                last_pulse = c;
            end
        end
        since_pulse = 196 - last_pulse;
        n_chk++; if (str_err != 0) $display("FAIL frame_stream: got %0d errors exp 0", str_err); else n_pass++;
        n_chk++; if (pol_err != 0) $display("FAIL hs_pol_stream: got %0d errors exp 0", pol_err); else n_pass++;
        n_chk++; if (ef_err != 0) $display("FAIL endframe_pos: got %0d errors exp 0", ef_err); else n_pass++;
        n_chk++; if (fc_err != 0) $display("FAIL frame_cnt_seq: got %0d errors exp 0", fc_err); else n_pass++;
        n_chk++; if (pulses != 2 || period != 98) $display("FAIL frame_period: got %0d pulses period %0d exp 2/98", pulses, period); else n_pass++;
        n_chk++; if (if_small.frame_cnt !== 8'd2) $display("FAIL frame_cnt_2: got %0d exp 2", if_small.frame_cnt); else n_pass++;
    endtask

    task automatic test_freeze_period();
        int cnt = 0, frz_err = 0;
        bit got = 1'b0;
        step(20);
        cnt = 20;
        if_small.enable = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step(1);
            cnt++;
            if (if_small.strVGA !== sm_exp(6, 1, 1'b0) || if_small.endframe !== 1'b0) frz_err++;
        end
        if_small.enable = 1'b1;
        n_chk++; if (frz_err != 0) $display("FAIL small_freeze: got %0d errors exp 0", frz_err); else n_pass++;
        for (int i = 0; i < 200 && !got; i++) begin
            step(1);
            cnt++;
            if (if_small.endframe === 1'b1) got = 1'b1;
        end
        n_chk++; if (!got || since_pulse + cnt != 108)
            $display("FAIL freeze_period: got %0d (seen=%0b) exp 108", since_pulse + cnt, got); else n_pass++;
    endtask

    task automatic test_wrap();
        int prev, incr_err = 0;
        bit wrapped = 1'b0;
        prev = int'(if_small.frame_cnt);
        for (int i = 0; i < 30000 && !wrapped; i++) begin
            step(1);
            if (if_small.endframe === 1'b1) begin
                if (int'(if_small.frame_cnt) != ((prev + 1) % 256)) incr_err++;
                if (prev == 255 && if_small.frame_cnt === 8'd0) wrapped = 1'b1;
                prev = int'(if_small.frame_cnt);
            end
        end
        n_chk++; if (!wrapped) $display("FAIL fc_wrap: got no 255->0 wrap exp wrap"); else n_pass++;
        n_chk++; if (incr_err != 0) $display("FAIL fc_incr: got %0d errors exp 0", incr_err); else n_pass++;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        if_def.enable = 1'b0;
        if_small.enable = 1'b0;
        #3;
        test_reset();
        test_line();
        test_freeze();
        test_reset_mid();
        test_frame();
        test_freeze_period();
        test_wrap();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
